// File: rtl/wired_alu_pipe.sv
// wired_alu_pipe: two-stage execute pipe around the combinational wired_alu.
// Stage A latches the selected operands and drives the ALU; stage B registers
// the ALU result and its writeback tag. Valid/ready handshake on both sides.
// Optional feature macro: WIRED_ALU_PIPE_FWD_EN (result forwarding into the
// operand mux through a last-result register).
module wired_alu_pipe #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      rs0_i,
  input  logic [31:0]      rs1_i,
  input  logic [31:0]      imm_i,
  input  logic             use_imm_i,
  input  logic [31:0]      pc_i,
  input  logic [1:0]       grand_op_i,
  input  logic [1:0]       op_i,
  input  logic [1:0]       fwd_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [31:0]      alu_r0_o,
  output logic [31:0]      alu_r1_o,
  output logic [31:0]      alu_pc_o,
  output logic [1:0]       alu_grand_o,
  output logic [1:0]       alu_op_o,
  input  logic [31:0]      alu_res_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      res_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [CNT_W-1:0] retired_o
);

  // Stage A (operand) registers
  logic             a_valid_q, a_valid_d;
  logic [31:0]      a_r0_q, a_r0_d;
  logic [31:0]      a_r1_q, a_r1_d;
  logic [31:0]      a_pc_q, a_pc_d;
  logic [1:0]       a_grand_q, a_grand_d;
  logic [1:0]       a_op_q, a_op_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;

  // Stage B (result) registers
  logic             b_valid_q, b_valid_d;
  logic [31:0]      b_res_q, b_res_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;

  logic [CNT_W-1:0] retired_q, retired_d;

  // Handshake terms
  logic             a_adv_s;
  logic             accept_s;
  logic             drain_s;
  logic [31:0]      op0_s;
  logic [31:0]      op1_s;

  // A moves to B when B is empty or B is being drained this cycle
  always_comb begin
    a_adv_s    = a_valid_q & (~b_valid_q | out_ready_i);
    in_ready_o = ~a_valid_q | a_adv_s;
    accept_s   = in_valid_i & in_ready_o & ~flush_i;
    drain_s    = b_valid_q & out_ready_i;
  end

`ifdef WIRED_ALU_PIPE_FWD_EN
  logic [31:0] last_res_q, last_res_d;
  logic [31:0] fwd_val_s;

  // Operand mux with forwarding; bypass the ALU output when the producer is
  // moving to B this very cycle so back-to-back dependent ops see it.
  always_comb begin
    if (a_adv_s) begin
      fwd_val_s = alu_res_i;
    end else begin
      fwd_val_s = last_res_q;
    end
    if (fwd_i[0]) begin
      op0_s = fwd_val_s;
    end else if (use_imm_i) begin
      op0_s = imm_i;
    end else begin
      op0_s = rs0_i;
    end
    if (fwd_i[1]) begin
      op1_s = fwd_val_s;
    end else begin
      op1_s = rs1_i;
    end
    if (a_adv_s & ~flush_i) begin
      last_res_d = alu_res_i;
    end else begin
      last_res_d = last_res_q;
    end
  end

  // Last-result register; only reset clears it, flush leaves it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      last_res_q <= 32'd0;
    end else begin
      last_res_q <= last_res_d;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^fwd_i;

  // Operand mux without forwarding: register or immediate for r0
  always_comb begin
    if (use_imm_i) begin
      op0_s = imm_i;
    end else begin
      op0_s = rs0_i;
    end
    op1_s = rs1_i;
  end
`endif

  // Next-state for both stages and the retired counter
  always_comb begin
    a_r0_d    = a_r0_q;
    a_r1_d    = a_r1_q;
    a_pc_d    = a_pc_q;
    a_grand_d = a_grand_q;
    a_op_d    = a_op_q;
    a_tag_d   = a_tag_q;
    b_res_d   = b_res_q;
    b_tag_d   = b_tag_q;

    if (flush_i) begin
      a_valid_d = 1'b0;
    end else if (accept_s) begin
      a_valid_d = 1'b1;
    end else if (a_adv_s) begin
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end

    if (accept_s) begin
      a_r0_d    = op0_s;
      a_r1_d    = op1_s;
      a_pc_d    = pc_i;
      a_grand_d = grand_op_i;
      a_op_d    = op_i;
      a_tag_d   = tag_i;
    end else begin
      a_r0_d    = a_r0_q;
    end

    if (flush_i) begin
      b_valid_d = 1'b0;
    end else if (a_adv_s) begin
      b_valid_d = 1'b1;
    end else if (drain_s) begin
      b_valid_d = 1'b0;
    end else begin
      b_valid_d = b_valid_q;
    end

    if (a_adv_s & ~flush_i) begin
      b_res_d = alu_res_i;
      b_tag_d = a_tag_q;
    end else begin
      b_res_d = b_res_q;
    end

    if (drain_s) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  // Pipeline state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_r0_q    <= 32'd0;
      a_r1_q    <= 32'd0;
      a_pc_q    <= 32'd0;
      a_grand_q <= 2'd0;
      a_op_q    <= 2'd0;
      a_tag_q   <= {TAG_W{1'b0}};
      b_valid_q <= 1'b0;
      b_res_q   <= 32'd0;
      b_tag_q   <= {TAG_W{1'b0}};
      retired_q <= {CNT_W{1'b0}};
    end else begin
      a_valid_q <= a_valid_d;
      a_r0_q    <= a_r0_d;
      a_r1_q    <= a_r1_d;
      a_pc_q    <= a_pc_d;
      a_grand_q <= a_grand_d;
      a_op_q    <= a_op_d;
      a_tag_q   <= a_tag_d;
      b_valid_q <= b_valid_d;
      b_res_q   <= b_res_d;
      b_tag_q   <= b_tag_d;
      retired_q <= retired_d;
    end
  end

  assign alu_r0_o    = a_r0_q;
  assign alu_r1_o    = a_r1_q;
  assign alu_pc_o    = a_pc_q;
  assign alu_grand_o = a_grand_q;
  assign alu_op_o    = a_op_q;
  assign out_valid_o = b_valid_q;
  assign res_o       = b_res_q;
  assign tag_o       = b_tag_q;
  assign retired_o   = retired_q;

endmodule

// File: tb/tb_wired_alu_pipe.sv
// Bench for wired_alu_pipe; includes a behavioural model of the wired_alu.
// Groups: 0=BW 1=LI 2=INT 3=SFT. Sub-ops as encoded in the alu model below.
module tb_wired_alu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, use_imm, out_valid, out_ready;
  logic [31:0] rs0, rs1, imm, pc, alu_r0, alu_r1, alu_pc, alu_res, res;
  logic [1:0]  grand, op, fwd, alu_grand, alu_op;
  logic [4:0]  tag, tag_out;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wired_alu_pipe #(.TAG_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rs0_i(rs0), .rs1_i(rs1), .imm_i(imm), .use_imm_i(use_imm), .pc_i(pc),
    .grand_op_i(grand), .op_i(op), .fwd_i(fwd), .tag_i(tag),
    .alu_r0_o(alu_r0), .alu_r1_o(alu_r1), .alu_pc_o(alu_pc),
    .alu_grand_o(alu_grand), .alu_op_o(alu_op), .alu_res_i(alu_res),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .res_o(res), .tag_o(tag_out), .retired_o(retired)
  );

  // Reference combinational ALU feeding the pipe
  always_comb begin
    alu_res = 32'd0;
    case (alu_grand)
      2'd0: case (alu_op)
        2'd0:    alu_res = alu_r0 & alu_r1;
        2'd1:    alu_res = alu_r0 | alu_r1;
        2'd2:    alu_res = alu_r0 ^ alu_r1;
        default: alu_res = alu_r0 & ~alu_r1;
      endcase
      2'd1: case (alu_op)
        2'd0:    alu_res = alu_r0 << 12;
        2'd1:    alu_res = alu_pc + (alu_r0 << 12);
        2'd2:    alu_res = alu_r0;
        default: alu_res = alu_pc + 32'd4;
      endcase
      2'd2: case (alu_op)
        2'd0:    alu_res = alu_r0 + alu_r1;
        2'd1:    alu_res = alu_r0 - alu_r1;
        2'd2:    alu_res = {31'd0, $signed(alu_r0) < $signed(alu_r1)};
        default: alu_res = {31'd0, alu_r0 < alu_r1};
      endcase
      default: case (alu_op)
        2'd0:    alu_res = alu_r0 << alu_r1[4:0];
        2'd1:    alu_res = alu_r0 >> alu_r1[4:0];
        2'd2:    alu_res = $signed(alu_r0) >>> alu_r1[4:0];
        default: alu_res = (alu_r0 << alu_r1[4:0]) | (alu_r0 >> (6'd32 - {1'b0, alu_r1[4:0]}));
      endcase
    endcase
  end

  typedef struct {
    logic        use_imm;
    logic [31:0] rs0, rs1, imm, pc;
    logic [1:0]  grand, op;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_op(input logic ui, input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] im, input logic [31:0] p, input logic [1:0] g,
                        input logic [1:0] o, input logic [1:0] f, input logic [4:0] t);
    use_imm = ui; rs0 = r0; rs1 = r1; imm = im; pc = p;
    grand = g; op = o; fwd = f; tag = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single op with out_ready held high: checks latency, result and tag
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    set_op(v.use_imm, v.rs0, v.rs1, v.imm, v.pc, v.grand, v.op, 2'd0, v.tag);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      tick();
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 32'd2);
    chk($sformatf("vec%0d_res", idx), res, v.exp);
    chk($sformatf("vec%0d_tag", idx), {27'd0, tag_out}, {27'd0, v.tag});
    tick();
  endtask

  initial begin
    int sent, got;
    logic [31:0] exp_fwd;

    //          use_imm rs0           rs1           imm        pc         grp   op    tag    expected
    vecs[0] = '{1'b0, 32'd5,        32'd3,        32'd0,     32'd0,     2'd2, 2'd0, 5'd7,  32'd8};
    vecs[1] = '{1'b1, 32'd0,        32'd0,        32'h12345, 32'd0,     2'd1, 2'd0, 5'd1,  32'h12345000};
    vecs[2] = '{1'b0, 32'd3,        32'd5,        32'd0,     32'd0,     2'd2, 2'd1, 5'd2,  32'hFFFFFFFE};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,     32'd0,     2'd2, 2'd2, 5'd3,  32'd1};
    vecs[4] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,     32'd0,     2'd2, 2'd3, 5'd4,  32'd0};
    vecs[5] = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,     32'd0,     2'd0, 2'd2, 5'd5,  32'h0FF00FF0};
    vecs[6] = '{1'b0, 32'h80000000, 32'd4,        32'd0,     32'd0,     2'd3, 2'd2, 5'd6,  32'hF8000000};
    vecs[7] = '{1'b1, 32'd0,        32'd0,        32'd1,     32'h1000,  2'd1, 2'd1, 5'd31, 32'h2000};
    vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,     32'd0,     2'd2, 2'd0, 5'd0,  32'd0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 2'd0, 5'd0);
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res", res, 32'd0);
    chk("rst_tag", {27'd0, tag_out}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_alu_r0", alu_r0, 32'd0);
    chk("rst_alu_grand", {30'd0, alu_grand}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], i);
    end
    chk("retired_after_table", retired, 32'd9);

    // Back-pressure: 4 ops, out_ready low for the first 7 cycles
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = (cyc >= 7);
      in_valid = (sent < 4);
      set_op(1'b0, 32'd10 + sent, 32'd0, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 5'd20 + sent[4:0]);
      #1;
      if (cyc == 2) chk("bp_accepts_before_full", sent, 32'd2);
      if (cyc >= 2 && cyc < 7) begin
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_held_res", res, 32'd10);
        chk("bp_held_valid", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (got < 4) begin
          chk("bp_order_res", res, 32'd10 + got);
          chk("bp_order_tag", {27'd0, tag_out}, 32'd20 + got);
        end else begin
          chk("bp_extra_result", got, 32'd3);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_total_results", got, 32'd4);
    chk("bp_retired", retired, 32'd13);

    // Flush with A and B full and a new op offered the same cycle
    out_ready = 1'b0;
    set_op(1'b0, 32'd100, 32'd1, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 5'd11);
    in_valid = 1'b1;
    tick();
    set_op(1'b0, 32'd200, 32'd1, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 5'd12);
    tick();
    chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    set_op(1'b0, 32'd300, 32'd1, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 5'd13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (out_valid) got++;
      tick();
    end
    chk("fl_no_emission", got, 32'd0);
    chk("fl_retired", retired, 32'd13);

    // Dependent back-to-back ops: op2 r0 forwarded from op1 when enabled
`ifdef WIRED_ALU_PIPE_FWD_EN
    exp_fwd = 32'd12;
`else
    exp_fwd = 32'd14;
`endif
    set_op(1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 5'd8);
    in_valid = 1'b1;
    tick();
    set_op(1'b0, 32'd4, 32'd10, 32'd0, 32'd0, 2'd2, 2'd0, 2'd1, 5'd9);
    #1;
    chk("fwd_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    fwd = 2'd0;
    chk("fwd_op1_valid", {31'd0, out_valid}, 32'd1);
    chk("fwd_op1_res", res, 32'd2);
    tick();
    chk("fwd_op2_valid", {31'd0, out_valid}, 32'd1);
    chk("fwd_op2_res", res, exp_fwd);
    chk("fwd_op2_tag", {27'd0, tag_out}, 32'd9);
    tick();
    chk("fwd_retired", retired, 32'd15);

    // Reset while B holds a stalled result and A holds another op
    out_ready = 1'b0;
    set_op(1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 5'd14);
    in_valid = 1'b1;
    tick();
    set_op(1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 2'd2, 2'd0, 2'd0, 5'd15);
    tick();
    in_valid = 1'b0;
    chk("mr_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_retired", retired, 32'd0);
    chk("mr_res", res, 32'd0);
    chk("mr_alu_r0", alu_r0, 32'd0);
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    run_op('{1'b0, 32'd40, 32'd2, 32'd0, 32'd0, 2'd2, 2'd0, 5'd16, 32'd42}, 99);
    chk("mr_retired_after", retired, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
